// File: rtl/uart_rx_capture.sv
// 8N1 UART receiver feeding a first-word fall-through byte FIFO, with framing/overflow/EOL flags.
// Define UART_RX_PARITY_EN for 8E1 framing with an extra parity_err_o output.
module uart_rx_capture #(
  parameter int unsigned CLKS_PER_BIT = 32,
  parameter int unsigned FIFO_DEPTH   = 16,
  parameter logic [7:0]  EOL_CHAR     = 8'h0A
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               rx_i,
  output logic [7:0]                         data_o,
  output logic                               valid_o,
  input  logic                               ready_i,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    count_o,
  output logic                               frame_err_o,
  output logic                               overflow_o,
  output logic                               line_done_o
`ifdef UART_RX_PARITY_EN
  ,
  output logic                               parity_err_o
`endif
);

  localparam int unsigned CntW  = $clog2(CLKS_PER_BIT);
  localparam int unsigned AddrW = $clog2(FIFO_DEPTH);
  localparam int unsigned OccW  = $clog2(FIFO_DEPTH + 1);

  typedef logic [CntW-1:0] baud_t;
  localparam baud_t BitLoad  = baud_t'(CLKS_PER_BIT - 1);
  localparam baud_t HalfLoad = baud_t'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop,
    StWaitIdle
  } state_e;

  state_e      state_q, state_d;
  baud_t       baud_q, baud_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  shift_q, shift_d;
  logic        rx_meta_q, rx_s_q;
  logic        expire;

  logic        push_req, ferr_set;
  logic        frame_err_q, line_done_q, overflow_q;

  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [AddrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [OccW-1:0]  count_q, count_d;
  logic            full, pop, push_ok;

`ifdef UART_RX_PARITY_EN
  logic par_bad_q, par_bad_d;
  logic par_err_set, parity_err_q;
`endif

  assign expire = (baud_q == '0);

  // State register plus receive datapath; the synchronizer idles at line-high.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      baud_q    <= '0;
      idx_q     <= '0;
      shift_q   <= '0;
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
`ifdef UART_RX_PARITY_EN
      par_bad_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      rx_meta_q <= rx_i;
      rx_s_q    <= rx_meta_q;
`ifdef UART_RX_PARITY_EN
      par_bad_q <= par_bad_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    baud_d  = expire ? baud_q : baud_q - baud_t'(1);
    idx_d   = idx_q;
    shift_d = shift_q;
`ifdef UART_RX_PARITY_EN
    par_bad_d = par_bad_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (!rx_s_q) begin
          state_d = StStart;
          baud_d  = HalfLoad;
        end
      end
      StStart: begin
        if (expire) begin
          if (rx_s_q) begin
            state_d = StIdle;
          end else begin
            state_d = StData;
            idx_d   = '0;
            baud_d  = BitLoad;
          end
        end
      end
      StData: begin
        if (expire) begin
          shift_d = {rx_s_q, shift_q[7:1]};
          idx_d   = idx_q + 3'd1;
          baud_d  = BitLoad;
          if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      StParity: begin
        if (expire) begin
          par_bad_d = ^{shift_q, rx_s_q};
          baud_d    = BitLoad;
          state_d   = StStop;
        end
      end
`endif
      StStop: begin
        if (expire) state_d = rx_s_q ? StIdle : StWaitIdle;
      end
      StWaitIdle: begin
        if (rx_s_q) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    ferr_set = (state_q == StStop) && expire && !rx_s_q;
`ifdef UART_RX_PARITY_EN
    push_req    = (state_q == StStop) && expire && rx_s_q && !par_bad_q;
    par_err_set = (state_q == StParity) && expire && (^{shift_q, rx_s_q});
`else
    push_req    = (state_q == StStop) && expire && rx_s_q;
`endif
  end

  // FIFO: a pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign valid_o = (count_q != '0);
  assign full    = (count_q == OccW'(FIFO_DEPTH));
  assign pop     = valid_o && ready_i;
  assign push_ok = push_req && (!full || pop);

  always_comb begin
    count_d = count_q;
    unique case ({push_ok, pop})
      2'b10:   count_d = count_q + OccW'(1);
      2'b01:   count_d = count_q - OccW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n && push_ok) mem_q[wr_ptr_q] <= shift_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      frame_err_q <= 1'b0;
      line_done_q <= 1'b0;
      overflow_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_q <= 1'b0;
`endif
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AddrW'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + AddrW'(1);
      count_q     <= count_d;
      frame_err_q <= ferr_set;
      line_done_q <= push_ok && (shift_q == EOL_CHAR);
      overflow_q  <= overflow_q | (push_req && full && !pop);
`ifdef UART_RX_PARITY_EN
      parity_err_q <= par_err_set;
`endif
    end
  end

  assign data_o      = valid_o ? mem_q[rd_ptr_q] : 8'h00;
  assign count_o     = count_q;
  assign frame_err_o = frame_err_q;
  assign line_done_o = line_done_q;
  assign overflow_o  = overflow_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err_o = parity_err_q;
`endif

endmodule

// File: tb/tb_uart_rx_capture.sv
// Directed bench for uart_rx_capture: table of single frames plus hand-written corner sequences.
module tb_uart_rx_capture;

  localparam int CPB   = 32;
  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_i = 1'b1;
  logic       ready_i = 1'b0;
  logic [7:0] data_o;
  logic       valid_o;
  logic [4:0] count_o;
  logic       frame_err_o;
  logic       overflow_o;
  logic       line_done_o;
`ifdef UART_RX_PARITY_EN
  logic       parity_err_o;
`endif

  always #5 clk = ~clk;

  uart_rx_capture #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEPTH),
    .EOL_CHAR    (8'h0A)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_i       (rx_i),
    .data_o     (data_o),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .count_o    (count_o),
    .frame_err_o(frame_err_o),
    .overflow_o (overflow_o),
    .line_done_o(line_done_o)
`ifdef UART_RX_PARITY_EN
    ,
    .parity_err_o(parity_err_o)
`endif
  );

  int checks = 0;
  int errors = 0;
  int ferr_total = 0;
  int ld_total = 0;

  // Pulse counters; one-cycle pulses are seen exactly once at the falling edge.
  always @(negedge clk) begin
    if (frame_err_o) ferr_total <= ferr_total + 1;
    if (line_done_o) ld_total <= ld_total + 1;
  end

  typedef struct {
    logic [7:0] tx;
    int         stop_low;
    logic [7:0] exp_data;
    logic [4:0] exp_count;
    int         exp_ferr;
    int         exp_ld;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_data"}, data_o, 0);
    check({tag, "_valid"}, valid_o, 0);
    check({tag, "_count"}, count_o, 0);
    check({tag, "_ferr"}, frame_err_o, 0);
    check({tag, "_ovf"}, overflow_o, 0);
    check({tag, "_ldone"}, line_done_o, 0);
  endtask

  task automatic send_bit(input logic b, input int n);
    rx_i = b;
    repeat (n) @(negedge clk);
  endtask

  // Start bit + 8 data bits; the caller finishes the stop bit.
  task automatic send_head(input logic [7:0] d);
    send_bit(1'b0, CPB);
    for (int i = 0; i < 8; i++) send_bit(d[i], CPB);
  endtask

  task automatic send_frame(input logic [7:0] d, input int stop_low);
    send_head(d);
    if (stop_low > 0) send_bit(1'b0, stop_low * CPB);
    send_bit(1'b1, CPB);
  endtask

  task automatic pop_one();
    ready_i = 1'b1;
    @(negedge clk);
    ready_i = 1'b0;
  endtask

  initial begin
    int f0;
    int l0;
    int seen;
    logic [7:0] exp_b;

    vecs[0] = '{8'h65, 0, 8'h65, 5'd1, 0, 0};
    vecs[1] = '{8'h41, 0, 8'h41, 5'd1, 0, 0};
    vecs[2] = '{8'h0A, 0, 8'h0A, 5'd1, 0, 1};
    vecs[3] = '{8'h33, 2, 8'h00, 5'd0, 1, 0};
    vecs[4] = '{8'h34, 0, 8'h34, 5'd1, 0, 0};
    vecs[5] = '{8'hFF, 0, 8'hFF, 5'd1, 0, 0};
    vecs[6] = '{8'h00, 0, 8'h00, 5'd1, 0, 0};
    vecs[7] = '{8'h80, 0, 8'h80, 5'd1, 0, 0};
    vecs[8] = '{8'h0B, 0, 8'h0B, 5'd1, 0, 0};

    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Latency: stop-bit midpoint is CPB/2 cycles into the stop bit.
    send_head(8'h65);
    rx_i = 1'b1;
    repeat (CPB / 2 - 1) @(negedge clk);
    check("lat_not_early", valid_o, 0);
    seen = 0;
    for (int i = 0; i < 4 && seen == 0; i++) begin
      @(negedge clk);
      if (valid_o) seen = 1;
    end
    check("lat_valid", seen, 1);
    check("lat_data", data_o, 8'h65);
    check("lat_count", count_o, 1);
    pop_one();
    check("lat_pop_valid", valid_o, 0);
    check("lat_pop_count", count_o, 0);
    repeat (CPB) @(negedge clk);

    for (int v = 0; v < 9; v++) begin
      f0 = ferr_total;
      l0 = ld_total;
      send_frame(vecs[v].tx, vecs[v].stop_low);
      repeat (4) @(negedge clk);
      check($sformatf("vec%0d_count", v), count_o, vecs[v].exp_count);
      check($sformatf("vec%0d_data", v), data_o, vecs[v].exp_data);
      check($sformatf("vec%0d_ferr", v), ferr_total - f0, vecs[v].exp_ferr);
      check($sformatf("vec%0d_ldone", v), ld_total - l0, vecs[v].exp_ld);
      if (valid_o) pop_one();
      check($sformatf("vec%0d_drained", v), count_o, 0);
    end

    // Short low glitch while idle must be rejected silently.
    f0 = ferr_total;
    send_bit(1'b0, 8);
    send_bit(1'b1, 40);
    check("glitch_count", count_o, 0);
    check("glitch_ferr", ferr_total - f0, 0);
    send_frame(8'h41, 0);
    repeat (4) @(negedge clk);
    check("glitch_next_data", data_o, 8'h41);
    check("glitch_next_count", count_o, 1);
    pop_one();

    // Overflow: 17 bytes into a 16-entry FIFO with no consumer.
    for (int i = 0; i <= DEPTH; i++) send_frame(8'(i), 0);
    repeat (4) @(negedge clk);
    check("ovf_count", count_o, DEPTH);
    check("ovf_flag", overflow_o, 1);
    for (int i = 0; i < DEPTH; i++) begin
      check($sformatf("ovf_drain%0d", i), data_o, i);
      pop_one();
    end
    check("ovf_empty", valid_o, 0);
    check("ovf_sticky", overflow_o, 1);

    // Reset in the middle of DATA with one byte queued.
    send_frame(8'h77, 0);
    repeat (4) @(negedge clk);
    check("pre_rst_count", count_o, 1);
    send_bit(1'b0, CPB);
    for (int i = 0; i < 3; i++) send_bit(1'b1 & (i == 1), CPB);
    rst_n = 1'b0;
    rx_i  = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    check_reset_outputs("midrst");
    f0 = ferr_total;
    repeat (400) @(negedge clk);
    check("midrst_no_push", count_o, 0);
    check("midrst_no_ferr", ferr_total - f0, 0);
    send_frame(8'hC3, 0);
    repeat (4) @(negedge clk);
    check("midrst_next_data", data_o, 8'hC3);
    check("midrst_next_count", count_o, 1);
    pop_one();

    // Full FIFO, consumer pops exactly in the push cycle of 0x55.
    for (int i = 0; i < DEPTH; i++) send_frame(8'h80 + 8'(i), 0);
    repeat (4) @(negedge clk);
    check("full_count", count_o, DEPTH);
    send_head(8'h55);
    rx_i = 1'b1;
    repeat (CPB / 2 + 2) @(negedge clk);
    ready_i = 1'b1;
    @(negedge clk);
    ready_i = 1'b0;
    repeat (CPB) @(negedge clk);
    check("fullpop_count", count_o, DEPTH);
    check("fullpop_ovf", overflow_o, 0);
    for (int i = 0; i < DEPTH; i++) begin
      exp_b = (i < DEPTH - 1) ? 8'h81 + 8'(i) : 8'h55;
      check($sformatf("fullpop_drain%0d", i), data_o, exp_b);
      pop_one();
    end
    check("fullpop_empty", valid_o, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
